// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the memory arbiter.
// The master drives a request (address, store data, byte mask, read strobe);
// the slave answers with read data and a one-cycle done pulse.
interface mem_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rstrb;
  logic [31:0] rdata;
  logic        done;

  modport master (
    output addr, wdata, wmask, rstrb,
    input  rdata, done
  );

  modport slave (
    input  addr, wdata, wmask, rstrb,
    output rdata, done
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported Memory block between the RISC-V core
// (port m0) and a second bus master (port m1, DMA or debug loader).
// Each access runs IDLE -> ISSUE -> DONE: the winner's request is latched on
// leaving IDLE, the memory port is driven for exactly one cycle from the
// latches, and read data returns with a one-cycle done pulse.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate winners on a tie;
// by default port 0 always wins a tie.
module mem_arbiter (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  output logic          mem_rstrb,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        start;
  logic        pend0;
  logic        pend1;
  logic        prefer1;
  logic        win;
  logic        grant;
  logic        last;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        rstrb_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        done0;
  logic        done1;

  assign pend0 = m0.rstrb | (|m0.wmask);
  assign pend1 = m1.rstrb | (|m1.wmask);

  // Pick the winner among pending requests; only matters on a tie.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // Serve whichever port was not served last, so neither can starve.
    prefer1 = ~last;
`else
    // Fixed priority to the CPU; last is still tracked but does not steer.
    prefer1 = last & 1'b0;
`endif
    win = 1'b0;
    if (pend0 && pend1) begin
      win = prefer1;
    end else if (pend1) begin
      win = 1'b1;
    end
  end

  // Next-state logic; start marks the IDLE->ISSUE edge that latches a request.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch and per-port read-data hold registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rstrb_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        grant   <= win;
        last    <= win;
        addr_q  <= win ? m1.addr  : m0.addr;
        wdata_q <= win ? m1.wdata : m0.wdata;
        wmask_q <= win ? m1.wmask : m0.wmask;
        rstrb_q <= win ? m1.rstrb : m0.rstrb;
      end
      if (state == DONE && rstrb_q) begin
        if (grant) begin
          rdata1_q <= mem_rdata;
        end else begin
          rdata0_q <= mem_rdata;
        end
      end
    end
  end

  // The memory port comes only from registers, so no requester input reaches
  // it combinationally; strobes are gated by ISSUE and drop as soon as reset
  // forces the state back to IDLE.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = (state == ISSUE) ? wmask_q : 4'b0000;
  assign mem_rstrb = (state == ISSUE) & rstrb_q;

  assign done0 = (state == DONE) & ~grant;
  assign done1 = (state == DONE) &  grant;

  // Fresh memory data is forwarded during the done cycle, the held copy otherwise.
  assign m0.done  = done0;
  assign m1.done  = done1;
  assign m0.rdata = done0 ? mem_rdata : rdata0_q;
  assign m1.rdata = done1 ? mem_rdata : rdata1_q;

endmodule
